// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// One load/store is accepted at a time over a valid/ready handshake. It is
// held for LATENCY cycles, then committed (store) or answered (load) with a
// one-cycle response pulse. Misaligned or out-of-range accesses are flagged
// and never touch the word array.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit          LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The full 30-bit word index is compared, so high address bits can never
  // alias onto a valid word.
  function automatic logic addr_err(input logic [31:0] addr);
    addr_err = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_W);
  endfunction

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        write_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        req_ready_r;
  logic        busy_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;
  logic [31:0] mem_r [DEPTH];

  logic             exec_s;
  logic             ex_write_s;
  logic [31:0]      ex_addr_s;
  logic [31:0]      ex_wdata_s;
  logic             ex_err_s;
  logic [IDX_W-1:0] ex_idx_s;

  // Select the access executed on the edge entering RESP: the captured
  // request normally, or the live inputs when LATENCY is 1.
  always_comb begin
    exec_s     = 1'b0;
    ex_write_s = write_r;
    ex_addr_s  = addr_r;
    ex_wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        if (LAT_ONE && req_valid) begin
          exec_s     = 1'b1;
          ex_write_s = req_write;
          ex_addr_s  = req_addr;
          ex_wdata_s = req_wdata;
        end else begin
          exec_s = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          exec_s = 1'b1;
        end else begin
          exec_s = 1'b0;
        end
      end
      default: exec_s = 1'b0;
    endcase
    ex_err_s = addr_err(ex_addr_s);
    ex_idx_s = ex_addr_s[IDX_W+1:2];
  end

  // Handshake FSM with capture registers and registered response outputs;
  // reset has priority over a coinciding RESP entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      write_r      <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_error_r <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r     <= req_write;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (LAT_ONE) begin
              state_r <= RESP;
            end else begin
              cnt_r   <= CNT_LOAD;
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
      if (exec_s) begin
        resp_valid_r <= 1'b1;
        resp_error_r <= ex_err_s;
        resp_rdata_r <= (ex_err_s || ex_write_s) ? 32'd0 : mem_r[ex_idx_s];
      end
    end
  end

  // Word array: cleared by reset, written only by an error-free store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (exec_s && ex_write_s && !ex_err_s) begin
      mem_r[ex_idx_s] <= ex_wdata_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_error = resp_error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance (a) and a
// LATENCY=1 instance (b) share the request bus and are compared against a
// word-array model with directed and randomized accesses.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        a_req_ready, a_resp_valid, a_resp_error, a_busy;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_error, b_busy;
  logic [31:0] b_resp_rdata;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mem_m [2][DEPTH];

  always #5 clk = ~clk;

  // cycle counter used to measure acceptance/response spacing
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_error(a_resp_error), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_error(b_resp_error), .busy(b_busy)
  );

  function automatic logic o_ready(input int w); return (w == 0) ? a_req_ready : b_req_ready; endfunction
  function automatic logic o_busy(input int w); return (w == 0) ? a_busy : b_busy; endfunction
  function automatic logic o_valid(input int w); return (w == 0) ? a_resp_valid : b_resp_valid; endfunction
  function automatic logic o_err(input int w); return (w == 0) ? a_resp_error : b_resp_error; endfunction
  function automatic logic [31:0] o_rdata(input int w); return (w == 0) ? a_resp_rdata : b_resp_rdata; endfunction

  // Reference memory: applies one access by address arithmetic.
  function automatic void model_access(input int w, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [7:0] wi;
    er = ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'(DEPTH));
    rd = 32'd0;
    if (!er) begin
      wi = 8'(addr / 32'd4);
      if (wr) mem_m[w][wi] = wd;
      else    rd = mem_m[w][wi];
    end
  endfunction

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++) mem_m[w][i] = 32'd0;
  endfunction

  task automatic set_valid(input int w, input logic v);
    if (w == 0) valid_a = v; else valid_b = v;
  endtask

  // One access: request offered at a negedge, random garbage held on the bus
  // with valid high while busy, valid dropped in the response cycle.
  task automatic txn(input int w, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     output logic rdy, output logic [31:0] rd, output logic er,
                     output int lat, output int busy_n, output int acc);
    @(negedge clk);
    rdy = o_ready(w);
    acc = cyc;
    req_write = wr; req_addr = addr; req_wdata = wd;
    set_valid(w, 1'b1);
    @(posedge clk); #1;
    req_write = 1'b1;
    req_addr  = 32'($urandom_range(0, 255)) * 32'd4;
    req_wdata = $urandom;
    lat = -1; busy_n = 0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_busy(w)) busy_n++;
      if (o_valid(w)) begin
        lat = k; rd = o_rdata(w); er = o_err(w);
        break;
      end
    end
    set_valid(w, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_checks++; if (o_ready(w) !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", w, o_ready(w)); end
      n_checks++; if (o_busy(w) !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", w, o_busy(w)); end
      n_checks++; if (o_valid(w) !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", w, o_valid(w)); end
      n_checks++; if (o_rdata(w) !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", w, o_rdata(w)); end
      n_checks++; if (o_err(w) !== 1'b0) begin n_fail++; $display("FAIL reset_error[%0d]: got %b expected 0", w, o_err(w)); end
    end
    model_clear();
    reset = 1'b1;
  endtask

  task automatic test_load_basic();
    logic rdy, er, eer; logic [31:0] rd, erd; int lat, bn, acc;
    txn(0, 1'b0, 32'h10, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h10, 32'd0, erd, eer);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL load10_ready: got %b expected 1", rdy); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL load10_latency: got %0d expected 2", lat); end
    n_checks++; if (bn != 2) begin n_fail++; $display("FAIL load10_busy_cycles: got %0d expected 2", bn); end
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL load10_rdata: got %h expected %h", rd, erd); end
    n_checks++; if (er !== eer) begin n_fail++; $display("FAIL load10_error: got %b expected %b", er, eer); end
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b0 || a_req_ready !== 1'b1) begin n_fail++; $display("FAIL load10_after_busy: got busy=%b ready=%b expected 0/1", a_busy, a_req_ready); end
  endtask

  task automatic test_store_load();
    logic rdy1, rdy2, er, eer; logic [31:0] rd, erd; int lat, bn, acc1, acc2;
    txn(0, 1'b1, 32'h20, 32'hDEAD_BEEF, rdy1, rd, er, lat, bn, acc1);
    model_access(0, 1'b1, 32'h20, 32'hDEAD_BEEF, erd, eer);
    n_checks++; if (rd !== 32'd0 || er !== 1'b0 || lat != 2) begin n_fail++; $display("FAIL store20_resp: got rdata=%h err=%b lat=%0d expected 0/0/2", rd, er, lat); end
    txn(0, 1'b0, 32'h20, 32'd0, rdy2, rd, er, lat, bn, acc2);
    model_access(0, 1'b0, 32'h20, 32'd0, erd, eer);
    n_checks++; if (rd !== erd || erd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load20_rdata: got %h expected %h", rd, erd); end
    n_checks++; if (rdy2 !== 1'b1 || (acc2 - acc1) != 3) begin n_fail++; $display("FAIL store_load_spacing: got ready=%b gap=%0d expected 1/3", rdy2, acc2 - acc1); end
  endtask

  task automatic test_misaligned();
    logic rdy, er, eer; logic [31:0] rd, erd; int lat, bn, acc;
    txn(0, 1'b1, 32'h22, 32'h5555_AAAA, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b1, 32'h22, 32'h5555_AAAA, erd, eer);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 2) begin n_fail++; $display("FAIL store22_error: got err=%b rdata=%h lat=%0d expected 1/0/2", er, rd, lat); end
    txn(0, 1'b0, 32'h20, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h20, 32'd0, erd, eer);
    n_checks++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL load20_after_misaligned: got %h err=%b expected %h err=0", rd, er, erd); end
  endtask

  task automatic test_out_of_range();
    logic rdy, er, eer; logic [31:0] rd, erd; int lat, bn, acc;
    txn(0, 1'b1, 32'h0, 32'hCAFE_F00D, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b1, 32'h0, 32'hCAFE_F00D, erd, eer);
    txn(0, 1'b0, 32'h400, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h400, 32'd0, erd, eer);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load400_oor: got err=%b rdata=%h expected 1/0", er, rd); end
    txn(0, 1'b1, 32'h8000_0000, 32'h1111_2222, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b1, 32'h8000_0000, 32'h1111_2222, erd, eer);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_highbit_oor: got err=%b expected 1", er); end
    txn(0, 1'b0, 32'h0, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h0, 32'd0, erd, eer);
    n_checks++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL load0_no_wrap: got %h err=%b expected %h err=0", rd, er, erd); end
  endtask

  task automatic test_reset_mid();
    logic rdy, er, eer, seen; logic [31:0] rd, erd; int lat, bn, acc;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h1234_5678; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL resetmid_in_wait: got busy=%b expected 1", a_busy); end
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    n_checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL resetmid_state: got valid=%b ready=%b busy=%b expected 0/1/0", a_resp_valid, a_req_ready, a_busy); end
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (a_resp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL resetmid_no_resp: got resp_valid seen=%b expected 0", seen); end
    txn(0, 1'b0, 32'h30, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h30, 32'd0, erd, eer);
    n_checks++; if (rd !== erd || erd !== 32'd0) begin n_fail++; $display("FAIL resetmid_load30: got %h expected %h", rd, erd); end
    txn(0, 1'b0, 32'h20, 32'd0, rdy, rd, er, lat, bn, acc);
    model_access(0, 1'b0, 32'h20, 32'd0, erd, eer);
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL resetmid_cleared20: got %h expected %h", rd, erd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] dat [3];
    int acyc [3];
    int rcyc [3];
    int i, nr;
    logic adv, rdy, er, eer;
    logic [31:0] rd, erd;
    int lat, bn, acc;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    for (int k = 0; k < 3; k++) begin dat[k] = $urandom; acyc[k] = -100; rcyc[k] = -1; end
    i = 0; nr = 0;
    @(negedge clk);
    req_write = 1'b1; req_addr = addrs[0]; req_wdata = dat[0]; valid_b = 1'b1;
    for (int c = 0; c < 30 && nr < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (b_resp_valid) begin
        if (nr < 3) rcyc[nr] = cyc;
        n_checks++; if (b_resp_rdata !== 32'd0 || b_resp_error !== 1'b0) begin n_fail++; $display("FAIL b2b_store_resp%0d: got rdata=%h err=%b expected 0/0", nr, b_resp_rdata, b_resp_error); end
        nr++;
      end
      adv = 1'b0;
      if (i < 3 && b_req_ready) begin
        acyc[i] = cyc;
        model_access(1, 1'b1, addrs[i], dat[i], erd, eer);
        i++; adv = 1'b1;
      end
      @(posedge clk); #1;
      if (adv) begin
        if (i < 3) begin req_addr = addrs[i]; req_wdata = dat[i]; end
        else valid_b = 1'b0;
      end
    end
    valid_b = 1'b0;
    n_checks++; if (nr != 3) begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected 3", nr); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rcyc[k] - acyc[k] != 1) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d expected 1", k, rcyc[k] - acyc[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (acyc[k+1] - acyc[k] != 2) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected 2", k, acyc[k+1] - acyc[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      txn(1, 1'b0, addrs[k], 32'd0, rdy, rd, er, lat, bn, acc);
      model_access(1, 1'b0, addrs[k], 32'd0, erd, eer);
      n_checks++; if (rd !== erd || erd !== dat[k] || lat != 1) begin n_fail++; $display("FAIL b2b_readback%0d: got %h lat=%0d expected %h lat=1", k, rd, lat, dat[k]); end
    end
  endtask

  task automatic test_random();
    logic rdy, er, eer, wr; logic [31:0] rd, erd, addr, wd; int lat, bn, acc, kind, elat;
    for (int w = 0; w < 2; w++) begin
      elat = (w == 0) ? 2 : 1;
      for (int n = 0; n < 60; n++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0)      addr = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
        else if (kind == 1) addr = (32'd256 + 32'($urandom_range(0, 2000))) * 32'd4;
        else if (kind == 2) addr = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
        else                addr = 32'($urandom_range(0, 63)) * 32'd4;
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        txn(w, wr, addr, wd, rdy, rd, er, lat, bn, acc);
        model_access(w, wr, addr, wd, erd, eer);
        n_checks++;
        if (rdy !== 1'b1 || lat != elat || bn != elat || rd !== erd || er !== eer) begin
          n_fail++;
          $display("FAIL random[%0d.%0d] wr=%b addr=%h: got rdy=%b lat=%0d busy=%0d rdata=%h err=%b expected 1/%0d/%0d/%h/%b",
                   w, n, wr, addr, rdy, lat, bn, rd, er, elat, elat, erd, eer);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    model_clear();
    test_reset();
    test_load_basic();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the MEM stage of the 5-stage MIPS pipeline. Accepts one load or store request at a time over a valid/ready handshake, holds it for a programmable latency, then commits the store or returns the load word with a one-cycle response pulse. `busy` feeds the hazard detection unit so the pipeline freezes while an access is outstanding. Word storage is internal; misaligned or out-of-range accesses are rejected with an error flag and never touch the array.

## Interface
- `DEPTH`, 256 — number of 32-bit words; valid word index 0..DEPTH-1.
- `LATENCY`, 2 — cycles from request acceptance to response; legal range 1..15.
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — synchronous, active-low; sampled on rising `clk`.
- `req_valid` input 1 — request present.
- `req_write` input 1 — 1 = store, 0 = load.
- `req_addr` input 32 — byte address; word index = `req_addr[31:2]`.
- `req_wdata` input 32 — store data.
- `req_ready` output 1 — responder can accept a request this cycle.
- `resp_valid` output 1 — one-cycle response pulse.
- `resp_rdata` output 32 — load data; 0 for stores and errors.
- `resp_error` output 1 — qualifies `resp_valid`; misaligned or out of range.
- `busy` output 1 — request outstanding; equals `!req_ready`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. If `req_valid`=1, capture `req_write`, `req_addr`, `req_wdata` and compute `err = (req_addr[1:0] != 0) || (req_addr[31:2] >= DEPTH)`.
  - If `LATENCY`=1, go to RESP.
  - Otherwise load the counter with `LATENCY`-2 and go to WAIT.
- WAIT: `req_ready`=0. Decrement the counter each cycle; go to RESP on the cycle the counter reads 0.
- At the edge entering RESP, the captured request is executed:
  - Store, no error: `mem[idx] <= wdata`; `resp_rdata` <= 0.
  - Load, no error: `resp_rdata` <= `mem[idx]`.
  - Error: no array access; `resp_rdata` <= 0; `resp_error` <= 1.
- RESP: `resp_valid`=1 for exactly one cycle; `req_ready`=0. Next state is IDLE unconditionally.
- `resp_rdata` and `resp_error` hold their values until the next RESP entry. They are meaningful only while `resp_valid`=1.
- No response back-pressure: the consumer always takes the pulse.
- Request inputs are ignored outside IDLE. Capture registers are never overwritten mid-access.
- Ordering: a load issued after a completed store to the same word returns the stored value.

## Timing
- Request accepted on edge E, at the end of IDLE cycle T with `req_valid`=1.
- `resp_valid` is high during cycle T+`LATENCY`. The store commit happens at the edge that begins that cycle.
- The next acceptance is possible at the end of cycle T+`LATENCY`+1, giving a throughput of one access per `LATENCY`+1 cycles.
- `busy` is high from cycle T+1 through T+`LATENCY` inclusive.
- Reset (`reset`=0 at an edge) forces:
  - state IDLE;
  - `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0;
  - counter = 0;
  - all array words = 0.
- Reset mid-operation (during WAIT) aborts the access: no store commit, no response. This holds even if the reset edge coincides with the would-be RESP entry, because reset has priority.
- A request asserted in the same cycle that reset is deasserted is not accepted. Acceptance first requires a sampled `reset`=1 edge with state IDLE.
- Address bits above the index width that are nonzero make the access out of range, so the index must not silently wrap.

## Test plan
- Reset then load (`LATENCY`=2), `req_addr`=0x10 → `resp_valid` two cycles after acceptance, `resp_rdata`=0, `resp_error`=0, `busy` high for exactly 2 cycles.
- Store 0xDEADBEEF to 0x20, then load 0x20 → the store response has `resp_rdata`=0; the load returns 0xDEADBEEF; the second acceptance comes no earlier than 3 cycles after the first.
- Store to misaligned 0x22, then load 0x20 → the store response has `resp_error`=1 and the array is unchanged; the load returns the previous value.
- Load at byte address 4*DEPTH (0x400 for DEPTH=256) → `resp_error`=1, `resp_rdata`=0; no wrap to word 0.
- `reset` driven low during WAIT of a store of 0x12345678 to 0x30 → no `resp_valid`; a later load of 0x30 returns 0; `req_ready`=1 the cycle after reset.
- `LATENCY`=1 build, back-to-back `req_valid` held high with stores to 0x0, 0x4, 0x8 → responses every 2nd cycle in order; all three words read back correctly.
